stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Controller that sequences a chain of cascaded mod-10 counters as a start/stop/clear stopwatch. It sits between the board push-buttons (already debounced and inverted to active-high at top level) and the hex-to-7-segment decoders. It owns the tick prescaler, the run/pause state machine and the BCD carry chain, and presents packed BCD digits for display.

## Interface
Parameters:
- TICK_DIV, 500000, clk cycles per count tick (50 MHz gives a 100 Hz tick); legal range ≥ 2.
- NDIG, 4, number of cascaded BCD digits; legal range 1–8.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  level from button, active-high; each rising edge toggles run/pause.
- clear  input  1  level from button, active-high; rising edge zeroes the count.
- lap  input  1  level from button, active-high; only used with STOPWATCH_LAP_EN.
- digits  output  4*NDIG  packed BCD; digits[3:0] is least significant.
- running  output  1  high in RUN.
- tick  output  1  one-cycle pulse on every count increment.
- wrap  output  1  one-cycle pulse when the count rolls from all-9s to all-0s.
- frozen  output  1  high while the lap display is held; constant 0 without the macro.

## Operation
- Input conditioning: each button input is registered once. The edge is `reg & ~prev_reg`. One action fires per press, however long the button is held.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop edge → RUN.
  - RUN + start_stop edge → PAUSE.
  - PAUSE + start_stop edge → RUN.
  - clear edge in any state → IDLE, with digits and prescaler zeroed.
  - clear and start_stop edges in the same cycle: clear wins and start_stop is discarded.
- Prescaler: counts 0..TICK_DIV-1 only in RUN, then wraps to 0. In PAUSE it holds its value, so resume continues the partial period. It is zeroed in IDLE.
- tick is asserted in the cycle where the prescaler equals TICK_DIV-1 and the state is RUN.
- Carry chain:
  - On tick, digit 0 increments.
  - Digit i increments when tick is high and digits 0..i-1 are all 9.
  - A digit at 9 that increments becomes 0. Each digit is 4 bits and never exceeds 9.
- Wrap: when all digits are 9 and tick is high, all digits go to 0 and wrap pulses in that same cycle.

## Timing
- Reset values: digits = 0, running = 0, tick = 0, wrap = 0, frozen = 0, state IDLE, prescaler 0, edge registers 0.
- Reset mid-count overrides everything on that edge.
- Latency, input to state: a button rising at clock edge k is registered at k; the state and running update at edge k+1.
- First tick after entering RUN from IDLE is TICK_DIV cycles after running rises.
- digits update on the clock edge following the tick cycle, i.e. registered at the end of the tick cycle.
- tick and wrap are combinational decodes of registered state. Each is high for exactly one cycle.
- A start_stop edge arriving in a tick cycle: the tick increment still happens and the state change takes effect on the same edge.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap edge in RUN or PAUSE copies the live count into a display register and sets frozen.
  - digits then shows the held value while counting continues internally.
  - A second lap edge clears frozen and digits tracks the live count again.
  - A clear edge clears frozen.
  - lap edges in IDLE are ignored.
- STOPWATCH_LAP_EN undefined: lap is ignored, frozen is tied to 0, digits always shows the live count, and no display register is built.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, PAUSE);
  - the BCD digit width constant (4);
  - the max BCD value constant (9).
- One sub-module, bcd_digit: a single mod-10 counter with inc_in, carry_out (inc_in && value==9) and synchronous clear. It is instantiated NDIG times with the carry chained.
- The prescaler, FSM and edge detection stay in the top module.

## Test plan
All scenarios use TICK_DIV=4 and NDIG=2.
- Reset, no presses for 20 cycles → digits=0x00, running=0, tick never asserted.
- start_stop pulse, then run 40 cycles → running high 2 cycles after the press; 10 ticks occur; digits=0x10, digit 1 carries exactly at 09→10.
- RUN 2 cycles into a period, then pause for 10 cycles, then resume → no tick during pause; next tick 2 cycles after resume; digits unchanged while paused.
- Count to 0x99, then one more tick → digits=0x00 and wrap pulses one cycle, coincident with that tick.
- clear and start_stop rising in the same cycle while in RUN at 0x37 → state IDLE, digits=0x00, running=0.
- With STOPWATCH_LAP_EN, lap at 0x12, run 8 more ticks → digits stays 0x12 with frozen=1; second lap → digits=0x20 with frozen=0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// ============================================================================
// Module : stopwatch_ctrl_pkg
// Brief  : Shared state encoding and BCD constants for the stopwatch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_ctrl_pkg;

    localparam int         c_bcd_w   = 4;
    localparam logic [3:0] c_bcd_max = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : Single mod-10 counter stage with carry out and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc_in,
    output logic [c_bcd_w-1:0] value,
    output logic               carry_out
);

    logic [c_bcd_w-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_value <= '0;
        end else if (inc_in) begin
            r_value <= (r_value == c_bcd_max) ? '0 : r_value + 1'b1;
        end
    end

    assign value     = r_value;
    assign carry_out = inc_in && (r_value == c_bcd_max);

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module : stopwatch_ctrl
// Brief  : Start/stop/clear stopwatch: button edge detect, run/pause FSM,
//          tick prescaler and cascaded BCD digits. Optional lap hold display
//          is enabled by defining STOPWATCH_LAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int NDIG     = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [c_bcd_w*NDIG-1:0] digits,
    output logic                    running,
    output logic                    tick,
    output logic                    wrap,
    output logic                    frozen
);

    localparam int                c_pw         = $clog2(TICK_DIV);
    localparam logic [c_pw-1:0]   c_presc_last = c_pw'(TICK_DIV - 1);

    logic              r_ss, r_ss_d, r_clr, r_clr_d;
    logic              w_ss_edge, w_clr_edge;
    state_t            r_state, w_state_next;
    logic [c_pw-1:0]   r_presc;
    logic              w_tick;
    logic [NDIG:0]     w_inc;
    logic [c_bcd_w*NDIG-1:0] w_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss    <= 1'b0;
            r_ss_d  <= 1'b0;
            r_clr   <= 1'b0;
            r_clr_d <= 1'b0;
        end else begin
            r_ss    <= start_stop;
            r_ss_d  <= r_ss;
            r_clr   <= clear;
            r_clr_d <= r_clr;
        end
    end

    assign w_ss_edge  = r_ss & ~r_ss_d;
    assign w_clr_edge = r_clr & ~r_clr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear has priority; a simultaneous start_stop edge is dropped.
    always_comb begin
        w_state_next = r_state;
        if (w_clr_edge) begin
            w_state_next = IDLE;
        end else if (w_ss_edge) begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Holds through PAUSE so a resume finishes the partial period.
    always_ff @(posedge clk) begin
        if (rst || w_clr_edge || (r_state == IDLE)) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
        end
    end

    assign w_tick   = (r_state == RUN) && (r_presc == c_presc_last);
    assign w_inc[0] = w_tick;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_clr_edge),
                .inc_in    (w_inc[gi]),
                .value     (w_live[gi*c_bcd_w +: c_bcd_w]),
                .carry_out (w_inc[gi+1])
            );
        end
    endgenerate

    assign tick    = w_tick;
    assign wrap    = w_inc[NDIG];
    assign running = (r_state == RUN);

`ifdef STOPWATCH_LAP_EN
    logic                    r_lap, r_lap_d, r_frozen;
    logic                    w_lap_edge;
    logic [c_bcd_w*NDIG-1:0] r_hold;

    assign w_lap_edge = r_lap & ~r_lap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap    <= 1'b0;
            r_lap_d  <= 1'b0;
            r_frozen <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_lap   <= lap;
            r_lap_d <= r_lap;
            if (w_clr_edge) begin
                r_frozen <= 1'b0;
            end else if (w_lap_edge && (r_state != IDLE)) begin
                r_frozen <= ~r_frozen;
                if (!r_frozen) begin
                    r_hold <= w_live;
                end
            end
        end
    end

    assign frozen = r_frozen;
    assign digits = r_frozen ? r_hold : w_live;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign frozen       = 1'b0;
    assign digits       = w_live;
`endif

endmodule

`default_nettype wire
